// File: rtl/cache_bus_arbiter.sv
// Two-to-one arbiter sharing the sram-like bridge port between inst and data caches.
// Latency: grant and address are presented in the same cycle as the request. One bubble separates transactions.
// Backpressure: the owner is held until m_data_ok arrives, and the other side waits ungranted.
// Ports: i_* / d_* are the cache sides (req/addr_ok/data_ok handshake), m_* is the bridge side,
//        busy = transaction in flight, owner = current or last grantee (0 inst, 1 data).
module cache_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_req,
  input  logic                  i_wr,
  input  logic [1:0]            i_size,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_addr_ok,
  output logic                  i_data_ok,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [1:0]            d_size,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_addr_ok,
  output logic                  d_data_ok,
  output logic                  m_req,
  output logic                  m_wr,
  output logic [1:0]            m_size,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_addr_ok,
  input  logic                  m_data_ok,
  output logic                  busy,
  output logic                  owner
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   gnt;
  logic   sel;
  logic   sel_req;

  // Round-robin on a tie: the side that was not served last wins.
  // With no request the value is unused, so it just follows owner_q.
  always_comb begin
    gnt = owner_q;
    if (i_req && d_req) begin
      gnt = ~last_q;
    end else if (d_req) begin
      gnt = 1'b1;
    end else if (i_req) begin
      gnt = 1'b0;
    end
  end

  // In IDLE the fresh grant drives the bus; afterwards the owner stays locked.
  assign sel     = (state_q == ST_IDLE) ? gnt : owner_q;
  assign sel_req = sel ? d_req : i_req;

  // resetn gates m_req so that nothing leaks to the bridge while reset is held.
  // An owner dropping req in ADDR simply deasserts m_req and parks there.
  assign m_req = resetn &
                 (((state_q == ST_IDLE) && (i_req || d_req)) ||
                  ((state_q == ST_ADDR) && sel_req));

  assign m_wr    = sel ? d_wr    : i_wr;
  assign m_size  = sel ? d_size  : i_size;
  assign m_addr  = sel ? d_addr  : i_addr;
  assign m_wdata = sel ? d_wdata : i_wdata;

  assign i_addr_ok = m_addr_ok & m_req & ~sel;
  assign d_addr_ok = m_addr_ok & m_req &  sel;

  // Only a data phase that is actually pending is acknowledged. Stray or late
  // m_data_ok pulses seen in IDLE/ADDR are dropped.
  assign i_data_ok = resetn & m_data_ok & (state_q == ST_DATA) & ~owner_q;
  assign d_data_ok = resetn & m_data_ok & (state_q == ST_DATA) &  owner_q;

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  assign busy  = (state_q != ST_IDLE);
  assign owner = owner_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (m_req) begin
          owner_d = gnt;
          last_d  = gnt;
          state_d = m_addr_ok ? ST_DATA : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_req && m_addr_ok) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (m_data_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Bench for cache_bus_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic compared against a transaction-level reference model.
// Inputs change on the falling edge, and outputs are sampled 1 ns later.
module tb_cache_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_req = 0, i_wr = 0, d_req = 0, d_wr = 0;
  logic [1:0]  i_size = 2'b10, d_size = 2'b10;
  logic [31:0] i_addr = 0, i_wdata = 0, d_addr = 0, d_wdata = 0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [31:0] m_rdata = 0;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic        m_req, m_wr, busy, owner;
  logic [1:0]  m_size;
  logic        m_addr_ok = 0, m_data_ok = 0;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state: one transaction at a time, tracked as
  // "in flight", "address accepted", who owns it and who was served last.
  logic mdl_active, mdl_accepted, mdl_owner, mdl_last;

  always #5 clk = ~clk;

  cache_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .busy(busy), .owner(owner)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic clear_inputs();
    i_req = 0; d_req = 0; i_wr = 0; d_wr = 0; i_size = 2'b10; d_size = 2'b10;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    mdl_active = 0; mdl_accepted = 0; mdl_owner = 0; mdl_last = 0;
  endtask

  // Directed vectors. flags = {m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, busy}
  typedef struct {
    logic        rst;
    logic        ireq, dreq, aok, dok;
    logic [31:0] rdata;
    logic [5:0]  flags;
    logic        sel;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input logic rst, input logic ireq, input logic dreq,
                             input logic aok, input logic dok, input logic [31:0] rdata,
                             input logic [5:0] flags, input logic sel);
    vec_t r;
    r.rst = rst; r.ireq = ireq; r.dreq = dreq; r.aok = aok; r.dok = dok;
    r.rdata = rdata; r.flags = flags; r.sel = sel;
    return r;
  endfunction

  logic       e_req, e_side;
  logic [6:0] e_flags;

  initial begin
    // Single data read: accept at cycle 0, data at cycle 3.
    vt.push_back(v(1, 0,1,1,0, 32'h0,         6'b101000, 1));
    vt.push_back(v(0, 0,0,0,0, 32'h0,         6'b000001, 0));
    vt.push_back(v(0, 0,0,0,0, 32'h0,         6'b000001, 0));
    vt.push_back(v(0, 0,0,0,1, 32'hDEAD_BEEF, 6'b000011, 0));
    // Ties after reset: data, then (after a bubble) inst, then data again.
    vt.push_back(v(1, 1,1,1,0, 32'h0,         6'b101000, 1));
    vt.push_back(v(0, 1,0,0,1, 32'h0BAD_0001, 6'b000011, 0));
    vt.push_back(v(0, 1,1,0,0, 32'h0,         6'b100000, 0));
    vt.push_back(v(0, 1,1,1,0, 32'h0,         6'b110001, 0));
    vt.push_back(v(0, 0,1,0,1, 32'h1234_5678, 6'b000101, 0));
    vt.push_back(v(0, 1,1,1,0, 32'h0,         6'b101000, 1));
    vt.push_back(v(0, 0,0,0,1, 32'h0BAD_F00D, 6'b000011, 0));
    // Delayed accept on an inst request while data starts asking.
    vt.push_back(v(0, 1,0,0,0, 32'h0,         6'b100000, 0));
    vt.push_back(v(0, 1,1,0,0, 32'h0,         6'b100001, 0));
    vt.push_back(v(0, 1,1,0,0, 32'h0,         6'b100001, 0));
    vt.push_back(v(0, 1,1,0,0, 32'h0,         6'b100001, 0));
    vt.push_back(v(0, 1,1,1,0, 32'h0,         6'b110001, 0));
    vt.push_back(v(0, 0,1,1,0, 32'h0,         6'b000001, 0));
    vt.push_back(v(0, 0,1,0,1, 32'hCAFE_0001, 6'b000101, 0));
    vt.push_back(v(0, 0,1,1,0, 32'h0,         6'b101000, 1));
    vt.push_back(v(0, 0,0,0,1, 32'h0000_0005, 6'b000011, 0));
    // Stray handshakes in IDLE with nobody requesting.
    vt.push_back(v(0, 0,0,1,1, 32'h0,         6'b000000, 0));
    vt.push_back(v(0, 0,0,1,1, 32'h0,         6'b000000, 0));

    i_addr = 32'h0000_2000;
    d_addr = 32'h1000_0040;

    do_reset();
    #1;
    chk("reset_state", {m_req, busy, owner, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}, 7'b0);

    foreach (vt[k]) begin
      if (vt[k].rst) do_reset();
      @(negedge clk);
      i_req = vt[k].ireq; d_req = vt[k].dreq;
      m_addr_ok = vt[k].aok; m_data_ok = vt[k].dok; m_rdata = vt[k].rdata;
      i_addr = 32'h0000_2000 + k;
      #1;
      chk($sformatf("vec%0d_flags", k),
          {m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, busy}, vt[k].flags);
      if (vt[k].flags[5])
        chk($sformatf("vec%0d_addr", k), m_addr, vt[k].sel ? d_addr : i_addr);
      if (vt[k].dok)
        chk($sformatf("vec%0d_rdata", k), {i_rdata, d_rdata}, {vt[k].rdata, vt[k].rdata});
    end

    // Write pass-through from the data side.
    do_reset();
    @(negedge clk);
    d_req = 1; d_wr = 1; d_size = 2'b00; d_addr = 32'h1000_0003; d_wdata = 32'h0000_00AB;
    m_addr_ok = 1;
    #1;
    chk("wr_bus", {m_req, m_wr, m_size, m_addr, m_wdata, d_addr_ok, i_addr_ok},
        {1'b1, 1'b1, 2'b00, 32'h1000_0003, 32'h0000_00AB, 1'b1, 1'b0});
    @(negedge clk);
    d_req = 0; m_addr_ok = 0; m_data_ok = 1;
    #1;
    chk("wr_done", {d_data_ok, i_data_ok, m_req}, 3'b100);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("wr_idle", {busy, owner}, 2'b01);

    // Reset during a pending inst read, then a late m_data_ok.
    do_reset();
    @(negedge clk);
    i_req = 1; i_addr = 32'h2000_0100; m_addr_ok = 1;
    #1;
    chk("rst_dat_grant", {i_addr_ok, d_addr_ok}, 2'b10);
    @(negedge clk);
    i_req = 0; m_addr_ok = 0;
    #1;
    chk("rst_dat_busy", busy, 1'b1);
    resetn = 0; d_req = 1; m_addr_ok = 1;
    #1;
    chk("rst_dat_held", {busy, m_req, d_addr_ok, i_addr_ok}, 4'b0000);
    @(negedge clk);
    resetn = 1; d_req = 0; m_addr_ok = 0; m_data_ok = 1;
    #1;
    chk("rst_dat_late_ok", {i_data_ok, d_data_ok, busy, m_req}, 4'b0000);
    @(negedge clk);
    m_data_ok = 0;
    #1;
    chk("rst_dat_idle", {busy, owner}, 2'b00);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      i_req = ($urandom_range(0, 3) != 0); d_req = ($urandom_range(0, 2) != 0);
      i_wr = $urandom_range(0, 1); d_wr = $urandom_range(0, 1);
      i_size = 2'($urandom_range(0, 2)); d_size = 2'($urandom_range(0, 2));
      i_addr = $urandom; d_addr = $urandom; i_wdata = $urandom; d_wdata = $urandom;
      m_rdata = $urandom;
      m_addr_ok = $urandom_range(0, 1); m_data_ok = ($urandom_range(0, 2) == 0);
      #1;
      if (!mdl_active) begin
        e_req = i_req | d_req;
        e_side = (i_req && d_req) ? ~mdl_last : d_req;
      end else if (!mdl_accepted) begin
        e_side = mdl_owner;
        e_req = mdl_owner ? d_req : i_req;
      end else begin
        e_side = mdl_owner;
        e_req = 1'b0;
      end
      e_flags = {e_req,
                 m_addr_ok & e_req & ~e_side,
                 m_addr_ok & e_req & e_side,
                 m_data_ok & mdl_accepted & ~mdl_owner,
                 m_data_ok & mdl_accepted & mdl_owner,
                 mdl_active, mdl_owner};
      chk($sformatf("rnd%0d_ctl", c),
          {m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, busy, owner}, e_flags);
      if (e_req)
        chk($sformatf("rnd%0d_bus", c), {m_wr, m_size, m_addr, m_wdata},
            e_side ? {d_wr, d_size, d_addr, d_wdata} : {i_wr, i_size, i_addr, i_wdata});
      if (c % 16 == 0)
        chk($sformatf("rnd%0d_rdata", c), {i_rdata, d_rdata}, {m_rdata, m_rdata});
      // Advance the model with the inputs seen at the coming rising edge.
      if (!mdl_active) begin
        if (e_req) begin
          mdl_active = 1; mdl_owner = e_side; mdl_last = e_side; mdl_accepted = m_addr_ok;
        end
      end else if (!mdl_accepted) begin
        if (e_req && m_addr_ok) mdl_accepted = 1;
      end else if (m_data_ok) begin
        mdl_active = 0; mdl_accepted = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
Two-to-one arbiter that shares the single sram-like port of the AXI interface bridge between the instruction cache and the data cache. Each cache issues one transaction at a time (req/addr_ok/data_ok handshake); the arbiter grants one requester, locks it until its data phase completes, and routes responses back to the owner only. It sits between the i_cache/d_cache miss/write-through paths and the sram-like-to-AXI converter.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of wdata/rdata

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
i_req  in  1  inst-cache request
i_wr  in  1  inst-cache write flag (normally 0)
i_size  in  2  inst-cache size (00 byte, 01 half, 10 word)
i_addr  in  ADDR_WIDTH  inst-cache address
i_wdata  in  DATA_WIDTH  inst-cache write data
i_rdata  out  DATA_WIDTH  read data to inst cache
i_addr_ok  out  1  address accepted, inst side
i_data_ok  out  1  data phase done, inst side
d_req, d_wr, d_size, d_addr, d_wdata, d_rdata, d_addr_ok, d_data_ok  same directions/widths as i_*, data-cache side
m_req  out  1  request to bridge
m_wr  out  1  write flag to bridge
m_size  out  2  size to bridge
m_addr  out  ADDR_WIDTH  address to bridge
m_wdata  out  DATA_WIDTH  write data to bridge
m_rdata  in  DATA_WIDTH  read data from bridge
m_addr_ok  in  1  bridge address accept
m_data_ok  in  1  bridge data done
busy  out  1  state != IDLE
owner  out  1  current/last grantee: 0 inst, 1 data

Behaviour:
- FSM states: IDLE, ADDR (request presented, waiting m_addr_ok), DATA (waiting m_data_ok). Registers: state, owner, last (last served).
- Reset (resetn low, async): state=IDLE, owner=0, last=0 (so data wins first tie). While resetn low: m_req=0, all *_addr_ok/*_data_ok=0.
- Grant in IDLE (combinational, same cycle): only d_req -> data; only i_req -> inst; both -> requester != last (round-robin). Result is gnt.
- m_wr/m_size/m_addr/m_wdata muxed from gnt in IDLE, from owner in ADDR/DATA. m_req = (IDLE & (i_req|d_req)) | (ADDR & owner's req).
- IDLE with request: owner<=gnt, last<=gnt. If m_addr_ok same cycle -> DATA, else -> ADDR. Zero-cycle address latency.
- ADDR: owner locked; new requests from the other side are not granted. m_addr_ok -> DATA.
- DATA: m_req=0. m_data_ok -> IDLE. Next grant earliest the following cycle (one bubble between transactions).
- x_addr_ok = m_addr_ok & m_req & (granted side == x). x_data_ok = m_data_ok & (state==DATA) & (owner == x). Never both sides in one cycle.
- i_rdata = d_rdata = m_rdata (broadcast); only the data_ok qualifies.
- Ignored events: m_data_ok in IDLE/ADDR; m_addr_ok while m_req=0; owner dropping req in ADDR (stay in ADDR, m_req=0, protocol violation, no recovery required).
- Reset mid-transaction: return to IDLE immediately; any late m_data_ok from the aborted transfer is ignored in IDLE.
- busy = (state != IDLE). No combinational path from m_data_ok to m_req.

Test Plan:
- Single data read: d_req=1, d_addr=0x1000_0040, bridge asserts m_addr_ok at cycle 0, m_data_ok at cycle 3 with m_rdata=0xDEAD_BEEF -> d_addr_ok in cycle 0, d_data_ok in cycle 3, d_rdata=0xDEAD_BEEF, i_addr_ok/i_data_ok stay 0.
- Simultaneous requests after reset: i_req=d_req=1 -> data granted first (m_addr=d_addr); after d_data_ok, one idle cycle, then inst granted; third tie grants data again.
- Delayed accept: m_addr_ok held low 4 cycles while d_req asserts mid-wait on inst transaction -> m_addr stays i_addr, state ADDR, no d_addr_ok until inst completes.
- Write pass-through: d_req=1, d_wr=1, d_size=2'b00, d_addr=0x...03, d_wdata=0x0000_00AB -> m_wr=1, m_size=00, m_addr/m_wdata identical, d_data_ok on m_data_ok.
- Stray handshakes: m_data_ok pulse in IDLE and m_addr_ok with no request -> no *_ok outputs, state unchanged.
- Reset in DATA: resetn low during pending inst read, release, then m_data_ok pulse -> i_data_ok stays 0, state IDLE, busy=0.
